// File: rtl/bram_intrf_pkg.sv
// Shared FSM state encoding and AXI response codes for the AXI4-Lite to BRAM bridge.
package bram_intrf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } bridge_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave to single-port BRAM bridge: one outstanding transaction,
// round-robin read/write arbitration, SLVERR for words beyond BRAM_DEPTH.
module axil_bram_bridge
  import bram_intrf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 1024,
  parameter int BRAM_ADDR  = $clog2(BRAM_DEPTH),
  parameter int AXI_ADDR   = BRAM_ADDR + $clog2(DATA_WIDTH/8) + 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [AXI_ADDR-1:0]       s_awaddr,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic [1:0]                s_bresp,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  input  logic [AXI_ADDR-1:0]       s_araddr,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      en_o,
  output logic [DATA_WIDTH/8-1:0]   we_o,
  output logic [BRAM_ADDR-1:0]      addr_o,
  output logic [DATA_WIDTH-1:0]     wrdata_o,
  input  logic [DATA_WIDTH-1:0]     rddata_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int WORD_W = AXI_ADDR - OFFS;
  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(BRAM_DEPTH);

  bridge_state_t state, state_nx;

  logic              live;
  logic              aw_held, w_held, held_none;
  logic              prio_write;
  logic              oor;
  logic [1:0]        wait_cnt;
  logic [WORD_W-1:0] aw_word, ar_word;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              aw_oor, ar_oor;
  logic              aw_hs, w_hs, ar_hs, wr_start;
  logic              unused_addr_bits;

  assign ar_word   = s_araddr[AXI_ADDR-1:OFFS];
  assign aw_oor    = aw_word >= DEPTH_W;
  assign ar_oor    = ar_word >= DEPTH_W;
  assign held_none = !aw_held && !w_held;
  assign unused_addr_bits = ^{s_awaddr, s_araddr};

  // Readies stay low for one cycle after reset via 'live'; a read that wins
  // arbitration holds off AW/W so the losing write waits intact.
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_arready = 1'b0;
    if (state == IDLE && live) begin
      s_arready = held_none && !(prio_write && (s_awvalid || s_wvalid));
      s_awready = !aw_held && !(held_none && s_arvalid && !prio_write);
      s_wready  = !w_held  && !(held_none && s_arvalid && !prio_write);
    end
  end

  assign aw_hs    = s_awvalid && s_awready;
  assign w_hs     = s_wvalid && s_wready;
  assign ar_hs    = s_arvalid && s_arready;
  assign wr_start = (state == IDLE) && aw_held && w_held;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (aw_held && w_held) state_nx = WR_ISSUE;
        else if (ar_hs)        state_nx = RD_ISSUE;
      end
      WR_ISSUE: state_nx = WR_RESP;
      WR_RESP:  if (s_bready) state_nx = IDLE;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  if (wait_cnt == '0) state_nx = RD_RESP;
      RD_RESP:  if (s_rready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign s_bvalid = (state == WR_RESP);
  assign s_rvalid = (state == RD_RESP);
  assign en_o     = !rst && !oor && (state == WR_ISSUE || state == RD_ISSUE);
  assign we_o     = (!rst && !oor && state == WR_ISSUE) ? w_strb : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      live       <= 1'b0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      prio_write <= 1'b1;
      oor        <= 1'b0;
      wait_cnt   <= '0;
      aw_word    <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      addr_o     <= '0;
      wrdata_o   <= '0;
      s_rdata    <= '0;
      s_bresp    <= OKAY;
      s_rresp    <= OKAY;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_word <= s_awaddr[AXI_ADDR-1:OFFS];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
      if (wr_start) begin
        oor        <= aw_oor;
        s_bresp    <= aw_oor ? SLVERR : OKAY;
        prio_write <= 1'b0;
        if (!aw_oor) begin
          addr_o   <= aw_word[BRAM_ADDR-1:0];
          wrdata_o <= w_data;
        end
      end
      if (state == WR_RESP && s_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (ar_hs) begin
        oor        <= ar_oor;
        s_rresp    <= ar_oor ? SLVERR : OKAY;
        prio_write <= 1'b1;
        if (!ar_oor) addr_o <= ar_word[BRAM_ADDR-1:0];
      end
      if (state == RD_ISSUE) wait_cnt <= 2'(RD_LATENCY - 1);
      if (state == RD_WAIT) begin
        if (wait_cnt == '0) s_rdata <= oor ? '0 : rddata_i;
        else                wait_cnt <= wait_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Bench for axil_bram_bridge: table-driven AXI-Lite transactions with a
// BRAM model, plus scoreboard queues for BRAM ops and B/R responses.
module tb_axil_bram_bridge;

  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int RDL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [12:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata, s_rdata, wrdata_o, rddata_i;
  logic [3:0]  s_wstrb, we_o;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready, en_o;
  logic [1:0]  s_bresp, s_rresp;
  logic [9:0]  addr_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] data;
    bit          is_wr;
  } bram_op_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } resp_t;

  typedef struct {
    bit          is_wr;
    logic [12:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          gap;
    int          rdly;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  bram_op_t exp_bram[$];
  resp_t    exp_b[$];
  resp_t    exp_r[$];
  vec_t     vecs[14];
  logic [31:0] bram [0:DEPTH-1];

  axil_bram_bridge #(
    .DATA_WIDTH(DW),
    .BRAM_DEPTH(DEPTH),
    .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .wrdata_o(wrdata_o), .rddata_i(rddata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Registered-output BRAM, one cycle read latency.
  initial begin
    for (int i = 0; i < DEPTH; i++) bram[i] = '0;
    rddata_i = '0;
  end
  always @(posedge clk) begin
    if (en_o) begin
      for (int b = 0; b < 4; b++)
        if (we_o[b]) bram[addr_o][b*8 +: 8] <= wrdata_o[b*8 +: 8];
      rddata_i <= bram[addr_o];
    end
  end

  always @(negedge clk) begin
    bram_op_t op;
    if (en_o) begin
      if (exp_bram.size() == 0) chk("bram_spurious_en", 32'(en_o), 32'd0);
      else begin
        op = exp_bram.pop_front();
        chk("bram_we", 32'(we_o), 32'(op.we));
        chk("bram_addr", 32'(addr_o), 32'(op.addr));
        if (op.is_wr) chk("bram_wrdata", wrdata_o, op.data);
      end
    end else if (we_o != '0) chk("we_without_en", 32'(we_o), 32'd0);
    if (s_bvalid) begin
      if (exp_b.size() == 0) chk("b_spurious", 32'(s_bvalid), 32'd0);
      else begin
        chk("bresp", 32'(s_bresp), 32'(exp_b[0].resp));
        if (s_bready) void'(exp_b.pop_front());
      end
    end
    if (s_rvalid) begin
      if (exp_r.size() == 0) chk("r_spurious", 32'(s_rvalid), 32'd0);
      else begin
        chk("rdata", s_rdata, exp_r[0].rdata);
        chk("rresp", 32'(s_rresp), 32'(exp_r[0].resp));
        if (s_rready) void'(exp_r.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_write(input logic [12:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
    logic [10:0] word;
    word = addr[12:2];
    if (resp == 2'b00) exp_bram.push_back('{we: strb, addr: word[9:0], data: data, is_wr: 1'b1});
    exp_b.push_back('{rdata: 32'h0, resp: resp});
  endtask

  task automatic push_read(input logic [12:0] addr, input logic [31:0] rdata, input logic [1:0] resp);
    logic [10:0] word;
    word = addr[12:2];
    if (resp == 2'b00) exp_bram.push_back('{we: 4'h0, addr: word[9:0], data: 32'h0, is_wr: 1'b0});
    exp_r.push_back('{rdata: rdata, resp: resp});
  endtask

  task automatic axi_write(input logic [12:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int gap);
    bit aw_d = 0, w_d = 0, b_d = 0, aw_h, w_h, b_h;
    int c = 0;
    int aw_start = (gap < 0) ? -gap : 0;
    int w_start  = (gap > 0) ? gap : 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_bready = 1'b1;
    while (!b_d && c < 60) begin
      if (!aw_d && c >= aw_start) s_awvalid = 1'b1;
      if (!w_d && c >= w_start) s_wvalid = 1'b1;
      @(negedge clk);
      aw_h = s_awvalid && s_awready;
      w_h  = s_wvalid && s_wready;
      b_h  = s_bvalid && s_bready;
      tick();
      if (aw_h) begin aw_d = 1; s_awvalid = 1'b0; end
      if (w_h) begin w_d = 1; s_wvalid = 1'b0; end
      if (b_h) b_d = 1;
      c++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    chk("write_completed", 32'(b_d), 32'd1);
  endtask

  task automatic axi_read(input logic [12:0] addr, input int rdly);
    bit ar_d = 0, r_d = 0, h;
    int c = 0, n = 0;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b0;
    while (!ar_d && c < 40) begin
      @(negedge clk);
      h = s_arvalid && s_arready;
      tick();
      if (h) ar_d = 1;
      c++;
    end
    s_arvalid = 1'b0;
    chk("ar_accepted", 32'(ar_d), 32'd1);
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (s_rvalid) break;
    end
    chk("rd_latency", 32'(n - 1), 32'(RDL + 1));
    tick();
    repeat (rdly) tick();
    s_rready = 1'b1;
    c = 0;
    while (!r_d && c < 20) begin
      @(negedge clk);
      h = s_rvalid && s_rready;
      tick();
      if (h) r_d = 1;
      c++;
    end
    s_rready = 1'b0;
    chk("read_completed", 32'(r_d), 32'd1);
  endtask

  task automatic axi_both(input logic [12:0] waddr, input logic [31:0] wdata, input logic [12:0] raddr);
    bit b_d = 0, r_d = 0, aw_h, w_h, ar_h, b_h, r_h;
    int c = 0;
    s_awaddr = waddr; s_wdata = wdata; s_wstrb = 4'hF; s_araddr = raddr;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
    while (!(b_d && r_d) && c < 80) begin
      @(negedge clk);
      aw_h = s_awvalid && s_awready;
      w_h  = s_wvalid && s_wready;
      ar_h = s_arvalid && s_arready;
      b_h  = s_bvalid && s_bready;
      r_h  = s_rvalid && s_rready;
      tick();
      if (aw_h) s_awvalid = 1'b0;
      if (w_h) s_wvalid = 1'b0;
      if (ar_h) s_arvalid = 1'b0;
      if (b_h) b_d = 1;
      if (r_h) r_d = 1;
      c++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    chk("arb_both_done", {30'd0, b_d, r_d}, 32'd3);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 13'h0008, 32'hDEADBEEF, 4'hF,  2, 0, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 13'h0008, 32'h0,        4'h0,  0, 0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 13'h0014, 32'h11223344, 4'hF, -1, 0, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 13'h0014, 32'hAABBCCDD, 4'h5,  0, 0, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 13'h0017, 32'h0,        4'h0,  0, 3, 2'b00, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 13'h1000, 32'hCAFEF00D, 4'hF,  0, 0, 2'b10, 32'h0};
    vecs[6]  = '{1'b0, 13'h1000, 32'h0,        4'h0,  0, 0, 2'b10, 32'h0};
    vecs[7]  = '{1'b1, 13'h001C, 32'h55555555, 4'h0,  1, 0, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 13'h001C, 32'h0,        4'h0,  0, 0, 2'b00, 32'h0};
    vecs[9]  = '{1'b1, 13'h0FFC, 32'h0BADF00D, 4'hF,  0, 0, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 13'h0FFC, 32'h0,        4'h0,  0, 0, 2'b00, 32'h0BADF00D};
    vecs[11] = '{1'b0, 13'h1FFC, 32'h0,        4'h0,  0, 1, 2'b10, 32'h0};
    vecs[12] = '{1'b1, 13'h000C, 32'h00001234, 4'hF,  0, 0, 2'b00, 32'h0};
    vecs[13] = '{1'b0, 13'h000C, 32'h0,        4'h0,  0, 3, 2'b00, 32'h00001234};

    rst = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready", 32'(s_wready), 32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_en_we", {27'd0, en_o, we_o}, 32'd0);
    chk("rst_addr_o", 32'(addr_o), 32'd0);
    chk("rst_wrdata_o", wrdata_o, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_low_after_rst", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    @(negedge clk);
    chk("ready_idle", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
    tick();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        push_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].gap);
      end else begin
        push_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp);
        axi_read(vecs[i].addr, vecs[i].rdly);
      end
      tick();
    end

    // Reset while the write response is pending: response abandoned.
    push_write(13'h0014, 32'hFFFFFFFF, 4'h5, 2'b00);
    s_awaddr = 13'h0014; s_wdata = 32'hFFFFFFFF; s_wstrb = 4'h5;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_bvalid) break;
      tick();
      if (!s_awready) s_awvalid = 1'b0;
      if (!s_wready) s_wvalid = 1'b0;
    end
    chk("wr_resp_reached", 32'(s_bvalid), 32'd1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_b.delete();
    @(negedge clk);
    chk("rst_wr_resp_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_wr_resp_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    @(negedge clk);
    chk("readies_recover", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
    tick();

    // Simultaneous requests just after reset: write served first.
    push_write(13'h0020, 32'hA5A5A5A5, 4'hF, 2'b00);
    push_read(13'h0020, 32'hA5A5A5A5, 2'b00);
    axi_both(13'h0020, 32'hA5A5A5A5, 13'h0020);
    tick();
    push_write(13'h0020, 32'h5A5A5A5A, 4'hF, 2'b00);
    axi_write(13'h0020, 32'h5A5A5A5A, 4'hF, 0);
    tick();
    // Last op was a write, so the read now wins and sees the old data.
    push_read(13'h0020, 32'h5A5A5A5A, 2'b00);
    push_write(13'h0020, 32'h0F0F0F0F, 4'hF, 2'b00);
    axi_both(13'h0020, 32'h0F0F0F0F, 13'h0020);
    tick();
    push_read(13'h0020, 32'h0F0F0F0F, 2'b00);
    axi_read(13'h0020, 0);
    tick();
    push_read(13'h0014, 32'h11FF33FF, 2'b00);
    axi_read(13'h0014, 0);
    repeat (3) tick();

    chk("bram_queue_drained", 32'(exp_bram.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    chk("r_queue_drained", 32'(exp_r.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
